seq_mult_signed: RTL

SEQ_MULT_SIGNED -- requirements
Module: seq_mult_signed

---
 rtl/seq_mult_signed_if.sv | 26 ++
 rtl/seq_mult_signed.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed_if.sv
// Operand/result handshake bundle for the sequential signed/unsigned multiplier.
// The master drives operands and accepts the product; the slave is the multiplier.
interface seq_mult_signed_if #(
  parameter int Multiplicand_length = 8,
  parameter int Multiplier_length   = 4
);
  logic [Multiplicand_length-1:0]                   a;
  logic [Multiplier_length-1:0]                     b;
  logic                                             is_signed;
  logic                                             ab_valid;
  logic                                             ab_ready;
  logic [Multiplicand_length+Multiplier_length-1:0] z;
  logic                                             z_valid;
  logic                                             z_ready;
  logic                                             busy;

  modport master (
    output a, b, is_signed, ab_valid, z_ready,
    input  ab_ready, z, z_valid, busy
  );

  modport slave (
    input  a, b, is_signed, ab_valid, z_ready,
    output ab_ready, z, z_valid, busy
  );
endinterface

// File: rtl/seq_mult_signed.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Signed mode treats the multiplier MSB as negative weight (subtract on the
// last step) with a sign-extended multiplicand; unsigned mode zero-extends.
// All outputs come straight from registers.
module seq_mult_signed #(
  parameter int Multiplicand_length = 8,
  parameter int Multiplier_length   = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_mult_signed_if.slave    bus
);
  localparam int AW = Multiplicand_length;
  localparam int BW = Multiplier_length;
  localparam int ZW = AW + BW;
  localparam int W  = ZW + 1;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [BW-1:0]   mplier_q, mplier_d;
  logic            sgn_q, sgn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            ab_ready_q, ab_ready_d;
  logic            z_valid_q, z_valid_d;
  logic            busy_q, busy_d;
  logic            last_s;
  logic [W-1:0]    sum_s;

  // Widen the multiplicand to accumulator width, sign- or zero-extended by mode.
  function automatic logic [W-1:0] extend_a(input logic [AW-1:0] v, input logic s);
    logic [W-1:0] r;
    if (s) begin
      r = {{(W-AW){v[AW-1]}}, v};
    end else begin
      r = {{(W-AW){1'b0}}, v};
    end
    return r;
  endfunction

  // State and datapath registers; reset clears everything including z.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= {W{1'b0}};
      mcand_q    <= {W{1'b0}};
      mplier_q   <= {BW{1'b0}};
      sgn_q      <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      z_q        <= {ZW{1'b0}};
      ab_ready_q <= 1'b1;
      z_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
      z_q        <= z_d;
      ab_ready_q <= ab_ready_d;
      z_valid_q  <= z_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Partial-sum step: add the shifted multiplicand for a set bit, subtract it
  // on the MSB step in signed mode (two's complement MSB has negative weight).
  always_comb begin
    last_s = (cnt_q == CW'(BW - 1));
    sum_s  = acc_q;
    if (mplier_q[0]) begin
      if (sgn_q && last_s) begin
        sum_s = acc_q - mcand_q;
      end else begin
        sum_s = acc_q + mcand_q;
      end
    end else begin
      sum_s = acc_q;
    end
  end

  // Next-state and registered-output decode for IDLE -> CALC -> DONE.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sgn_d      = sgn_q;
    cnt_d      = cnt_q;
    z_d        = z_q;
    ab_ready_d = ab_ready_q;
    z_valid_d  = z_valid_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.ab_valid) begin
          state_d    = CALC;
          acc_d      = {W{1'b0}};
          mcand_d    = extend_a(bus.a, bus.is_signed);
          mplier_d   = bus.b;
          sgn_d      = bus.is_signed;
          cnt_d      = {CW{1'b0}};
          ab_ready_d = 1'b0;
          z_valid_d  = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = IDLE;
          ab_ready_d = 1'b1;
          z_valid_d  = 1'b0;
          busy_d     = 1'b0;
        end
      end
      CALC: begin
        acc_d    = sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          state_d   = DONE;
          z_d       = sum_s[ZW-1:0];
          z_valid_d = 1'b1;
        end else begin
          state_d   = CALC;
        end
      end
      DONE: begin
        if (bus.z_ready) begin
          state_d    = IDLE;
          z_valid_d  = 1'b0;
          ab_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          state_d    = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        ab_ready_d = 1'b1;
        z_valid_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign bus.ab_ready = ab_ready_q;
  assign bus.z_valid  = z_valid_q;
  assign bus.busy     = busy_q;
  assign bus.z        = z_q;

endmodule
